// File: rtl/mem_2r1w_be_if.sv
// Bus bundle for mem_2r1w_be: two read ports, one byte-enabled write port
// and the status outputs.
//   master : drives rd_addr0/1, wr_addr0, wr_din0, wr_be0, we0;
//            receives rd_dout0/1, busy, wr_drop
//   slave  : the memory side of the same signals
interface mem_2r1w_be_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
);
    logic [ADDR_WIDTH-1:0]     rd_addr0;
    logic [DATA_WIDTH-1:0]     rd_dout0;
    logic [ADDR_WIDTH-1:0]     rd_addr1;
    logic [DATA_WIDTH-1:0]     rd_dout1;
    logic [ADDR_WIDTH-1:0]     wr_addr0;
    logic [DATA_WIDTH-1:0]     wr_din0;
    logic [DATA_WIDTH/8-1:0]   wr_be0;
    logic                      we0;
    logic                      busy;
    logic                      wr_drop;

    modport master (
        output rd_addr0, rd_addr1, wr_addr0, wr_din0, wr_be0, we0,
        input  rd_dout0, rd_dout1, busy, wr_drop
    );

    modport slave (
        input  rd_addr0, rd_addr1, wr_addr0, wr_din0, wr_be0, we0,
        output rd_dout0, rd_dout1, busy, wr_drop
    );
endinterface

// File: rtl/mem_2r1w_be.sv
// Two-read / one-write memory with per-byte write enables.
// Used as the core register file and as a small data RAM.
//   clk  : clock, all state changes on the rising edge
//   rst  : synchronous reset, active-low
//   bus  : mem_2r1w_be_if.slave
//          rd_addr0/rd_dout0, rd_addr1/rd_dout1 : read ports
//          wr_addr0, wr_din0, wr_be0, we0       : write port
//          busy    : 1 while in reset or clearing (writes dropped, reads 0)
//          wr_drop : registered pulse, previous cycle's write was dropped
// READ_SYNC selects registered (1) or combinational (0) reads, BYPASS
// selects write-first forwarding, CLEAR_ON_RST zeroes every entry after
// reset release.
module mem_2r1w_be #(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 16,
    parameter int ADDR_WIDTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int READ_SYNC    = 1,
    parameter int BYPASS       = 1,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic           clk,
    input  logic           rst,
    mem_2r1w_be_if.slave   bus
);
    localparam int NBYTES = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0]   DEPTH_L  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);
    localparam bit BYPASS_EN = (BYPASS != 0);
    localparam bit CLEAR_EN  = (CLEAR_ON_RST != 0);

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_CLEAR = 2'd1,
        ST_READY = 2'd2
    } state_e;

    // Addresses at or above DEPTH do not exist (DEPTH need not be 2**n).
    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return ({1'b0, a} < DEPTH_L);
    endfunction

    // Replace the enabled bytes of old_w with the corresponding bytes of new_w.
    function automatic logic [DATA_WIDTH-1:0] be_merge(
        input logic [DATA_WIDTH-1:0] old_w,
        input logic [DATA_WIDTH-1:0] new_w,
        input logic [NBYTES-1:0]     be
    );
        logic [DATA_WIDTH-1:0] r;
        for (int i = 0; i < NBYTES; i++) begin
            if (be[i]) begin
                r[8*i +: 8] = new_w[8*i +: 8];
            end else begin
                r[8*i +: 8] = old_w[8*i +: 8];
            end
        end
        return r;
    endfunction

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_ptr_q, clr_ptr_d;
    logic                    clr_we_s;
    logic                    busy_s;
    logic                    wr_in_range_s;
    logic                    wr_acc_s;
    logic [DATA_WIDTH-1:0]   wr_old_s;
    logic [DATA_WIDTH-1:0]   wr_merge_s;
    logic                    wr_drop_q, wr_drop_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0]   rd_addr_s [2];
    logic [DATA_WIDTH-1:0]   rd_data_s [2];

    assign busy_s       = (state_q != ST_READY);
    assign rd_addr_s[0] = bus.rd_addr0;
    assign rd_addr_s[1] = bus.rd_addr1;

    // FSM next state: reset always wins; CLEAR walks clr_ptr over every entry.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        clr_we_s  = 1'b0;
        if (!rst) begin
            state_d   = ST_RST;
            clr_ptr_d = '0;
        end else begin
            case (state_q)
                ST_RST: begin
                    state_d   = CLEAR_EN ? ST_CLEAR : ST_READY;
                    clr_ptr_d = '0;
                end
                ST_CLEAR: begin
                    clr_we_s = 1'b1;
                    if (clr_ptr_q == LAST_IDX) begin
                        state_d = ST_READY;
                    end else begin
                        clr_ptr_d = clr_ptr_q + ADDR_WIDTH'(1);
                    end
                end
                ST_READY: begin
                    state_d = ST_READY;
                end
                default: begin
                    state_d   = ST_RST;
                    clr_ptr_d = '0;
                end
            endcase
        end
    end

    // FSM registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_RST;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // Write qualification and byte merge against the stored word.
    always_comb begin
        wr_in_range_s = in_range(bus.wr_addr0);
        wr_acc_s      = bus.we0 && !busy_s && wr_in_range_s;
        if (wr_in_range_s) begin
            wr_old_s = mem_q[bus.wr_addr0];
        end else begin
            wr_old_s = '0;
        end
        wr_merge_s = be_merge(wr_old_s, bus.wr_din0, bus.wr_be0);
        wr_drop_d  = rst && bus.we0 && (busy_s || !wr_in_range_s);
    end

    // Storage array: clear sequencer or accepted write; never reset directly
    // so contents survive rst when clearing is disabled.
    always_ff @(posedge clk) begin
        if (clr_we_s) begin
            mem_q[clr_ptr_q] <= '0;
        end else if (wr_acc_s) begin
            mem_q[bus.wr_addr0] <= wr_merge_s;
        end
    end

    // Read data per port, with optional forwarding of an accepted write.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data_s[p] = '0;
            if (in_range(rd_addr_s[p])) begin
                if (BYPASS_EN && wr_acc_s && (rd_addr_s[p] == bus.wr_addr0)) begin
                    rd_data_s[p] = wr_merge_s;
                end else begin
                    rd_data_s[p] = mem_q[rd_addr_s[p]];
                end
            end else begin
                rd_data_s[p] = '0;
            end
        end
    end

    // Drop-indicator register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_drop_q <= 1'b0;
        end else begin
            wr_drop_q <= wr_drop_d;
        end
    end

    assign bus.busy    = busy_s;
    assign bus.wr_drop = wr_drop_q;

    generate
        if (READ_SYNC != 0) begin : g_sync
            logic [DATA_WIDTH-1:0] rd_dout_q [2];
            logic [DATA_WIDTH-1:0] rd_dout_d [2];

            // Registered read data is zero while busy.
            always_comb begin
                for (int p = 0; p < 2; p++) begin
                    if (busy_s) begin
                        rd_dout_d[p] = '0;
                    end else begin
                        rd_dout_d[p] = rd_data_s[p];
                    end
                end
            end

            // Read output registers.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    rd_dout_q[0] <= '0;
                    rd_dout_q[1] <= '0;
                end else begin
                    rd_dout_q[0] <= rd_dout_d[0];
                    rd_dout_q[1] <= rd_dout_d[1];
                end
            end

            assign bus.rd_dout0 = rd_dout_q[0];
            assign bus.rd_dout1 = rd_dout_q[1];
        end else begin : g_comb
            // Combinational reads are forced to zero while rst is low or busy.
            assign bus.rd_dout0 = (!rst || busy_s) ? '0 : rd_data_s[0];
            assign bus.rd_dout1 = (!rst || busy_s) ? '0 : rd_data_s[1];
        end
    endgenerate
endmodule
